// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Serializes one instruction's decoded fields into an x86-64 byte stream,
//   one byte per cycle. Emission order: lock, segment, operand-size,
//   address-size and REX prefixes (0x00 = absent), opcode bytes (first byte
//   first), ModRM, SIB, displacement and immediate (both little-endian).
//   A malformed request produces a one-cycle err pulse and emits nothing.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   in_valid / in_ready        request handshake (in_ready high only in IDLE)
//   in_*_prefix                prefix bytes, 0x00 = absent
//   in_opcode / in_opcode_len  left-aligned opcode bytes, count 1..3
//   in_modrm_valid / in_modrm  optional ModRM byte
//   in_sib_valid / in_sib      optional SIB byte (requires ModRM)
//   in_disp / in_disp_size     displacement, 0, 1 or 4 bytes
//   in_imm / in_imm_size       immediate, 0, 1, 2, 4 or 8 bytes
//   out_valid / out_ready      byte handshake
//   out_byte / out_last        emitted byte, last-byte marker
//   err                        one-cycle pulse: request rejected
module instruction_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_lock_repeat_prefix,
  input  logic [7:0]  in_segment_branch_prefix,
  input  logic [7:0]  in_operand_size_prefix,
  input  logic [7:0]  in_address_size_prefix,
  input  logic [7:0]  in_rex_prefix,
  input  logic [23:0] in_opcode,
  input  logic [1:0]  in_opcode_len,
  input  logic        in_modrm_valid,
  input  logic [7:0]  in_modrm,
  input  logic        in_sib_valid,
  input  logic [7:0]  in_sib,
  input  logic [63:0] in_disp,
  input  logic [2:0]  in_disp_size,
  input  logic [63:0] in_imm,
  input  logic [3:0]  in_imm_size,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        err
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  // Every byte that could appear, in emission order:
  // 5 prefixes, 3 opcode, ModRM, SIB, 4 disp, 8 imm.
  localparam int NCAND = 22;

  state_t            state_reg, state_next;
  logic [7:0]        cand_byte [NCAND];
  logic [NCAND-1:0]  cand_valid;
  logic [7:0]        pack_bytes [16];
  logic [7:0]        byte_buf_reg [16];
  logic [4:0]        total_len;
  logic [3:0]        idx_reg;
  logic [3:0]        len_reg;
  logic              err_reg;
  logic              illegal;
  logic              accept;
  logic              unused_disp_hi;

  // Only the low four displacement bytes can ever be emitted.
  assign unused_disp_hi = ^in_disp[63:32];

  assign cand_byte[0]  = in_lock_repeat_prefix;
  assign cand_byte[1]  = in_segment_branch_prefix;
  assign cand_byte[2]  = in_operand_size_prefix;
  assign cand_byte[3]  = in_address_size_prefix;
  assign cand_byte[4]  = in_rex_prefix;
  assign cand_valid[0] = (in_lock_repeat_prefix != 8'h00);
  assign cand_valid[1] = (in_segment_branch_prefix != 8'h00);
  assign cand_valid[2] = (in_operand_size_prefix != 8'h00);
  assign cand_valid[3] = (in_address_size_prefix != 8'h00);
  assign cand_valid[4] = (in_rex_prefix != 8'h00);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_opcode
      assign cand_byte[5+gi]  = in_opcode[23-8*gi -: 8];
      assign cand_valid[5+gi] = (in_opcode_len > 2'(gi));
    end
  endgenerate

  assign cand_byte[8]  = in_modrm;
  assign cand_valid[8] = in_modrm_valid;
  assign cand_byte[9]  = in_sib;
  assign cand_valid[9] = in_sib_valid;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_disp
      assign cand_byte[10+gi]  = in_disp[8*gi +: 8];
      assign cand_valid[10+gi] = (in_disp_size > 3'(gi));
    end
    for (gi = 0; gi < 8; gi++) begin : g_imm
      assign cand_byte[14+gi]  = in_imm[8*gi +: 8];
      assign cand_valid[14+gi] = (in_imm_size > 4'(gi));
    end
  endgenerate

  // Compact the present bytes into a dense buffer. The running position
  // doubles as the total length; bytes beyond 16 are dropped, and any
  // such request is rejected as too long anyway.
  always_comb begin
    total_len = 5'd0;
    for (int i = 0; i < 16; i++) pack_bytes[i] = 8'h00;
    for (int i = 0; i < NCAND; i++) begin
      if (cand_valid[i]) begin
        if (total_len < 5'd16) pack_bytes[total_len[3:0]] = cand_byte[i];
        total_len = total_len + 5'd1;
      end
    end
  end

  always_comb begin
    illegal = 1'b0;
    if (in_opcode_len == 2'd0) illegal = 1'b1;
    if (!(in_disp_size == 3'd0 || in_disp_size == 3'd1 || in_disp_size == 3'd4))
      illegal = 1'b1;
    if (!(in_imm_size == 4'd0 || in_imm_size == 4'd1 || in_imm_size == 4'd2 ||
          in_imm_size == 4'd4 || in_imm_size == 4'd8))
      illegal = 1'b1;
    if (in_sib_valid && !in_modrm_valid) illegal = 1'b1;
    if (total_len > 5'd15) illegal = 1'b1;
  end

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && !illegal) state_next = EMIT;
      EMIT:    if (out_ready && out_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on in_* or out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    if (state_reg == IDLE) begin
      in_ready = 1'b1;
    end else begin
      out_valid = 1'b1;
      out_byte  = byte_buf_reg[idx_reg];
      out_last  = (idx_reg == len_reg - 4'd1);
    end
  end

  assign err = err_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_reg <= 4'd0;
      len_reg <= 4'd0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= accept && illegal;
      if (accept && !illegal) begin
        idx_reg <= 4'd0;
        len_reg <= total_len[3:0];
      end else if (out_valid && out_ready) begin
        idx_reg <= idx_reg + 4'd1;
      end
    end
  end

  // Byte buffer needs no reset: it is only observed while in EMIT,
  // which is entered solely through a load.
  always_ff @(posedge clk) begin
    if (accept && !illegal) begin
      for (int i = 0; i < 16; i++) byte_buf_reg[i] <= pack_bytes[i];
    end
  end

endmodule
